// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the fetch PC, drives the combinational ROM,
// buffers fetched words in a small FIFO and hands them to decode via valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          ADDR_BITS   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);

  localparam int          PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int          CNT_W   = PTR_W + 1;
  localparam logic [31:0] PC_MASK = ((32'd1 << ADDR_BITS) - 32'd1) & ~32'd3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // Keep only the word-aligned bits the ROM decodes; this also gives modulo wrap.
  function automatic logic [31:0] norm_pc(input logic [31:0] pc);
    return pc & PC_MASK;
  endfunction

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0]        pc_mem    [QUEUE_DEPTH];
  logic [31:0]        instr_mem [QUEUE_DEPTH];

  logic               deq;
  logic               push;
  logic               has_room;

  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0);
  assign deq       = out_valid & out_ready;
  assign has_room  = (count_q < CNT_W'(QUEUE_DEPTH)) | deq;
  assign push      = (state_q == ST_RUN) & ~halt_req & ~redirect_valid & has_room;

  // Head is gated so the outputs read zero whenever the queue is empty.
  assign out_instr = out_valid ? instr_mem[head_q] : 32'd0;
  assign out_pc    = out_valid ? pc_mem[head_q]    : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= norm_pc(RESET_PC);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]    <= pc_q;
      instr_mem[tail_q] <= imem_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    halted  = (state_q == ST_HALTED);

    if (redirect_valid) begin
      // Flush wins over everything, including a handshake in the same cycle.
      pc_d    = norm_pc(redirect_pc);
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = halt_req ? ST_HALTED : ST_RUN;
    end else begin
      if ((state_q == ST_RUN) && halt_req) begin
        state_d = ST_HALTED;
      end

      if (push) begin
        pc_d   = norm_pc(pc_q + 32'd4);
        tail_d = tail_q + PTR_W'(1);
      end
      if (deq) begin
        head_d = head_q + PTR_W'(1);
      end

      unique case ({push, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {pc, instr} pairs,
// a negedge monitor pops and compares every accepted head.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2),
    .ADDR_BITS   (7)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  // ROM: word n holds 0x1000_0000 + n
  assign imem_data = 32'h1000_0000 + (imem_addr >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = 32'h1000_0000 + (pc >> 2);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (sb.size() == 0) break;
    end
    chk("drain_remaining", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every accepted head must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_pc", out_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_out_pc", out_pc, e.pc);
        chk("sb_out_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    halt_req       = 1'b0;
    out_ready      = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);

    // Streaming with ready held high, through the 0x7C -> 0x00 wrap
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 34; i++) expect_pc(32'((i * 4) % 128));
    @(negedge clk);
    chk("first_valid_before_edge", 32'(out_valid), 32'd0);
    tick();
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      chk("stream_no_gap", 32'(out_valid), 32'd1);
      tick();
    end
    chk("stream_drained", 32'(sb.size()), 32'd0);
    out_ready = 1'b0;

    // Back-pressure from reset: queue fills to 2, head held at 0x00
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_head_pc", out_pc, 32'd0);
    end
    chk("stall_fetch_pc", imem_addr, 32'h08);
    chk("stall_valid", 32'(out_valid), 32'd1);
    expect_pc(32'h00);
    expect_pc(32'h04);
    expect_pc(32'h08);
    expect_pc(32'h0C);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("release_no_gap", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b0;
    chk("release_drained", 32'(sb.size()), 32'd0);

    // Redirect to 0x43 with a full queue (0x10, 0x14)
    chk("pre_redirect_head", out_pc, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    redirect_valid = 1'b0;
    chk("redir_valid_low", 32'(out_valid), 32'd0);
    chk("redir_fetch_pc", imem_addr, 32'h40);
    tick();
    chk("redir_first_valid", 32'(out_valid), 32'd1);
    chk("redir_first_pc", out_pc, 32'h40);
    chk("redir_first_instr", out_instr, 32'h1000_0010);
    expect_pc(32'h40);
    expect_pc(32'h44);
    out_ready = 1'b1;
    wait_drain(10);
    out_ready = 1'b0;
    tick();
    tick();

    // Halt with two entries queued: they drain, then nothing more
    halt_req  = 1'b1;
    out_ready = 1'b1;
    expect_pc(32'h48);
    expect_pc(32'h4C);
    wait_drain(10);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_empty", 32'(out_valid), 32'd0);
    tick();
    tick();
    tick();
    chk("halt_no_fetch", imem_addr, 32'h50);
    chk("halt_still_empty", 32'(out_valid), 32'd0);
    halt_req = 1'b0;
    tick();
    tick();
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_sticky_empty", 32'(out_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    expect_pc(32'h10);
    expect_pc(32'h14);
    tick();
    redirect_valid = 1'b0;
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_valid_low", 32'(out_valid), 32'd0);
    wait_drain(10);
    out_ready = 1'b0;

    // Asynchronous reset between edges while halted with an entry queued
    halt_req = 1'b1;
    tick();
    chk("pre_areset_halted", 32'(halted), 32'd1);
    chk("pre_areset_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 32'(out_valid), 32'd0);
    chk("areset_halted", 32'(halted), 32'd0);
    chk("areset_out_pc", out_pc, 32'd0);
    chk("areset_imem_addr", imem_addr, 32'd0);
    halt_req = 1'b0;
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    expect_pc(32'h00);
    expect_pc(32'h04);
    expect_pc(32'h08);
    wait_drain(10);
    out_ready = 1'b0;

    // Redirect together with halt_req: redirect applied, state HALTED
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    halt_req       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("redir_halt_halted", 32'(halted), 32'd1);
    chk("redir_halt_valid", 32'(out_valid), 32'd0);
    chk("redir_halt_pc", imem_addr, 32'h20);
    tick();
    tick();
    chk("redir_halt_no_push", 32'(out_valid), 32'd0);
    chk("redir_halt_pc_held", imem_addr, 32'h20);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
